// File: rtl/answer_judge.sv
// answer_judge: quiz-game player input. Synchronises/debounces two submit
// buttons, arbitrates first press (p1 wins ties), judges against ans, drives
// score triggers, wrong LED, question index and a sticky game_over.
// Optional question time limit: define JUDGE_TIMEOUT_EN.

// Per-player input path: 2-FF synchroniser plus debounce; one-cycle rise pulse
module answer_judge_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2, deb;
  logic [CW-1:0] cnt;

  // Accept a new level after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt  <= '0;
        deb  <= s2;
        rise <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module answer_judge #(
  parameter int DEB_CYCLES     = 16,
  parameter int RESULT_CYCLES  = 8,
  parameter int NUM_Q          = 6,
  parameter int WIN_SCORE      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p1_btn,
  input  logic       p2_btn,
  input  logic [2:0] p1_choice,
  input  logic [2:0] p2_choice,
  input  logic [2:0] ans,
  output logic [2:0] state,
  output logic       p1_score_trig,
  output logic       p2_score_trig,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic       wrong_led,
  output logic       game_over
);
  localparam int SW = $clog2(RESULT_CYCLES + 1);

  typedef enum logic [2:0] {S_WAIT, S_JUDGE, S_SHOW, S_NEXT, S_OVER} fsm_t;

  logic [1:0]      btn, rise, lock, trig;
  logic [1:0][2:0] sc;
  fsm_t            fsm;
  logic            pid;     // latched player: 0 = p1, 1 = p2
  logic [2:0]      choice;
  logic            adv;     // advance to NEXT after the SHOW window
  logic [SW-1:0]   scnt;

  assign btn           = {p2_btn, p1_btn};
  assign p1_score_trig = trig[0];
  assign p2_score_trig = trig[1];
  assign p1_score      = sc[0];
  assign p2_score      = sc[1];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_deb
      answer_judge_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn[g]),
        .rise (rise[g])
      );
    end
  endgenerate

`ifdef JUDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;  // WAIT time on this question, kept across retries
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Game FSM; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_WAIT;
      state     <= '0;
      sc        <= '0;
      trig      <= '0;
      lock      <= '0;
      wrong_led <= 1'b0;
      game_over <= 1'b0;
      pid       <= 1'b0;
      choice    <= '0;
      adv       <= 1'b0;
      scnt      <= '0;
`ifdef JUDGE_TIMEOUT_EN
      tmr       <= '0;
`endif
    end else begin
      case (fsm)
        S_WAIT: begin
`ifdef JUDGE_TIMEOUT_EN
          tmr <= tmr + 1'b1;
`endif
          if (rise[0] && !lock[0]) begin
            pid    <= 1'b0;
            choice <= p1_choice;
            fsm    <= S_JUDGE;
          end else if (rise[1] && !lock[1]) begin
            pid    <= 1'b1;
            choice <= p2_choice;
            fsm    <= S_JUDGE;
          end
`ifdef JUDGE_TIMEOUT_EN
          else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
            wrong_led <= 1'b1;
            adv       <= 1'b1;
            scnt      <= '0;
            fsm       <= S_SHOW;
          end
`endif
        end
        S_JUDGE: begin
          // 0, 6 and 7 are never legal answers
          if (choice == ans && choice >= 3'd1 && choice <= 3'd5) begin
            if (sc[pid] != 3'd7) sc[pid] <= sc[pid] + 1'b1;
            trig[pid] <= 1'b1;
            adv       <= 1'b1;
          end else begin
            wrong_led <= 1'b1;
            lock[pid] <= 1'b1;
            adv       <= 1'b0;
          end
          scnt <= '0;
          fsm  <= S_SHOW;
        end
        S_SHOW: begin
          if (scnt == SW'(RESULT_CYCLES - 1)) begin
            trig      <= '0;
            wrong_led <= 1'b0;
            fsm       <= (adv || (&lock)) ? S_NEXT : S_WAIT;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_NEXT: begin
          lock  <= '0;
          adv   <= 1'b0;
          state <= (state == 3'(NUM_Q - 1)) ? 3'd0 : state + 1'b1;
`ifdef JUDGE_TIMEOUT_EN
          tmr   <= '0;
`endif
          if (sc[0] >= 3'(WIN_SCORE) || sc[1] >= 3'(WIN_SCORE)) begin
            game_over <= 1'b1;
            fsm       <= S_OVER;
          end else begin
            fsm <= S_WAIT;
          end
        end
        S_OVER:  fsm <= S_OVER;
        default: fsm <= S_WAIT;
      endcase
    end
  end
endmodule
